// File: rtl/board_line_fetcher.sv
// board_line_fetcher: fetches one board row per hblank into a line buffer and
// serves the per-pixel block_type / play_area / score_area qualifiers.
module board_line_fetcher #(
  parameter int PLAY_X0   = 240,
  parameter int PLAY_Y0   = 80,
  parameter int CELL_LOG2 = 4,
  parameter int SCORE_X0  = 10,
  parameter int SCORE_Y0  = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_ce,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [2:0] rd_data,
  output logic [2:0] block_type,
  output logic       play_area,
  output logic       score_area,
  output logic [9:0] DrawX_o,
  output logic [9:0] DrawY_o
);
  typedef enum logic [1:0] {IDLE, REQ, LAST} state_t;
  state_t state, state_n;
  logic [4:0] row, row_n, fetch_row;
  logic [3:0] col, col_n, px_col;
  logic [9:0][2:0] line_buf;
  logic [10:0] dx, dy, ny;
  logic fetch_rows, trig, in_x, in_y, in_sx, in_sy;
  assign dx = {1'b0, DrawX};
  assign dy = {1'b0, DrawY};
  assign ny = (DrawY == 10'd524) ? 11'd0 : dy + 11'd1;
  assign fetch_rows = ny >= 11'(PLAY_Y0) && ny <= 11'(PLAY_Y0 + (20 << CELL_LOG2) - 1);
  assign trig = pix_ce && DrawX == 10'd640 && state == IDLE && fetch_rows;
  // offsets are only consumed once the range checks have passed
  assign fetch_row = 5'((ny - 11'(PLAY_Y0)) >> CELL_LOG2);
  assign in_x = dx >= 11'(PLAY_X0) && dx <= 11'(PLAY_X0 + (10 << CELL_LOG2) - 1);
  assign in_y = dy >= 11'(PLAY_Y0) && dy <= 11'(PLAY_Y0 + (20 << CELL_LOG2) - 1);
  assign px_col = 4'((dx - 11'(PLAY_X0)) >> CELL_LOG2);
  assign in_sx = dx >= 11'(SCORE_X0) && dx <= 11'(SCORE_X0 + 7);
  assign in_sy = dy >= 11'(SCORE_Y0) && dy <= 11'(SCORE_Y0 + 15);
  assign rd_en = state == REQ;
  assign rd_addr = rd_en ? {3'b0, row} * 8'd10 + {4'b0, col} : 8'd0;
  always_comb begin
    state_n = trig ? REQ : (state == REQ && col == 4'd9) ? LAST : (state == LAST) ? IDLE : state;
    col_n = (state == REQ && col != 4'd9) ? col + 4'd1 : 4'd0;
    row_n = trig ? fetch_row : row;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
    end
  // read data trails its request by one cycle, so REQ writes the previous column
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      line_buf <= '0;
      block_type <= '0;
      play_area <= 1'b0;
      score_area <= 1'b0;
      DrawX_o <= '0;
      DrawY_o <= '0;
    end else begin
      if (state == REQ && col != 4'd0) line_buf[col - 4'd1] <= rd_data;
      if (state == LAST) line_buf[9] <= rd_data;
      if (pix_ce) begin
        play_area <= in_x && in_y;
        block_type <= (in_x && in_y) ? line_buf[px_col] : 3'd0;
        score_area <= in_sx && in_sy;
        DrawX_o <= DrawX;
        DrawY_o <= DrawY;
      end
    end
endmodule

// File: tb/tb_board_line_fetcher.sv
// tb_board_line_fetcher: directed and randomized scans against a line-buffer model.
module tb_board_line_fetcher;
  logic Clk = 1'b0;
  logic Reset_n, pix_ce, rd_en, play_area, score_area;
  logic [9:0] DrawX, DrawY, DrawX_o, DrawY_o;
  logic [7:0] rd_addr;
  logic [2:0] rd_data = 3'd0;
  logic [2:0] block_type;
  logic [2:0] ram [200];
  int exp_buf [10];
  int total = 0, bad = 0;

  board_line_fetcher dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .block_type(block_type),
    .play_area(play_area), .score_area(score_area), .DrawX_o(DrawX_o), .DrawY_o(DrawY_o)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) if (rd_en) rd_data <= (rd_addr < 8'd200) ? ram[rd_addr] : 3'd0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic scan(input int x, input int y, input int n);
    int ny, row, ebt;
    bit fetch, play, score;
    ny = (y == 524) ? 0 : y + 1;
    fetch = x == 640 && ny >= 80 && ny <= 399;
    row = (ny - 80) / 16;
    play = x >= 240 && x <= 399 && y >= 80 && y <= 399;
    ebt = play ? exp_buf[(x - 240) / 16] : 0;
    score = x >= 10 && x <= 17 && y >= 10 && y <= 25;
    @(posedge Clk) #1;
    DrawX = 10'(x); DrawY = 10'(y); pix_ce = 1'b1;
    @(posedge Clk) #1;
    pix_ce = 1'b0;
    DrawX = 10'($urandom_range(0, 799)); DrawY = 10'($urandom_range(0, 524));
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("rd_en", int'(rd_en), int'(fetch && i < 10));
      if (fetch && i < 10) check("rd_addr", int'(rd_addr), row * 10 + i);
      if (i == 0 || i == n - 1) begin
        check("block_type", int'(block_type), ebt);
        check("play_area", int'(play_area), int'(play));
        check("score_area", int'(score_area), int'(score));
        check("DrawX_o", int'(DrawX_o), x);
        check("DrawY_o", int'(DrawY_o), y);
      end
    end
    if (fetch) for (int c = 0; c < 10; c++) exp_buf[c] = int'(ram[row * 10 + c]);
  endtask

  task automatic px(input int x, input int y);
    scan(x, y, (x == 640) ? 14 : 2);
  endtask

  initial begin
    for (int a = 0; a < 200; a++) ram[a] = 3'd0;
    ram[13] = 3'd3;
    for (int c = 0; c < 10; c++) exp_buf[c] = 0;
    Reset_n = 1'b0; pix_ce = 1'b0; DrawX = '0; DrawY = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst rd_en", int'(rd_en), 0);
    check("rst rd_addr", int'(rd_addr), 0);
    check("rst block_type", int'(block_type), 0);
    check("rst play_area", int'(play_area), 0);
    check("rst score_area", int'(score_area), 0);
    check("rst DrawX_o", int'(DrawX_o), 0);
    check("rst DrawY_o", int'(DrawY_o), 0);
    Reset_n = 1'b1;
    px(640, 78);
    px(640, 79);
    px(640, 95);
    px(288, 100);
    px(287, 100);
    px(640, 399);
    px(10, 10); px(17, 25); px(18, 25); px(10, 26); px(9, 10);
    px(399, 80); px(400, 80); px(240, 399); px(239, 200); px(300, 79); px(300, 400);
    px(640, 524);
    px(640, 398);
    // hold pix_ce low for 20 cycles across a fetch
    scan(640, 127, 20);
    // abort a fetch with reset during its 5th read cycle
    for (int c = 0; c < 10; c++) ram[20 + c] = 3'($urandom_range(1, 7));
    px(640, 95);
    @(posedge Clk) #1;
    DrawX = 10'd640; DrawY = 10'd111; pix_ce = 1'b1;
    @(posedge Clk) #1;
    pix_ce = 1'b0;
    repeat (5) @(negedge Clk);
    check("rd_en before abort", int'(rd_en), 1);
    Reset_n = 1'b0;
    #1;
    check("rd_en async drop", int'(rd_en), 0);
    check("DrawX_o async rst", int'(DrawX_o), 0);
    for (int c = 0; c < 10; c++) exp_buf[c] = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    px(288, 100); px(240, 112); px(270, 112); px(399, 112);
    px(640, 111);
    for (int c = 0; c < 10; c++) px(240 + 16 * c + int'($urandom_range(0, 15)), 112);
    // randomized scanning with board writes between lines
    for (int k = 0; k < 60; k++) begin
      int y;
      repeat ($urandom_range(0, 3)) ram[$urandom_range(0, 199)] = 3'($urandom);
      y = (k % 5 == 0) ? int'($urandom_range(0, 524)) : int'($urandom_range(79, 398));
      px(640, y);
      repeat (3) px(int'($urandom_range(225, 415)), (y >= 524) ? 0 : y + 1);
      if (k % 7 == 0) px(int'($urandom_range(0, 30)), int'($urandom_range(0, 40)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_line_fetcher.md
# board_line_fetcher

Producer side of the play-field colour path. It fetches one 10-cell board row from the board RAM during each horizontal blanking interval into a line buffer. In step with the VGA scan, it then supplies the per-pixel `block_type`, `play_area` and `score_area` qualifiers that the colour mapper consumes. The block sits between the VGA controller (`DrawX`/`DrawY`) and the colour mapper, and owns the board RAM read port.

## Interface
- `PLAY_X0`, default 240: first pixel column of the play area.
- `PLAY_Y0`, default 80: first pixel line of the play area.
- `CELL_LOG2`, default 4: log2 of the cell edge in pixels (16 px cells); the play area is 160×320 px.
- `SCORE_X0`, default 10 / `SCORE_Y0`, default 10: origin of the 8×16 score glyph box.
- `Clk` in 1: system clock, 50 MHz.
- `Reset_n` in 1: asynchronous, active-low reset.
- `pix_ce` in 1: pixel-clock enable, one `Clk` pulse per pixel.
- `DrawX`, `DrawY` in 10 each: current scan position from the VGA controller (800×525 total, 640×480 active).
- `rd_en` out 1: board RAM read strobe.
- `rd_addr` out 8: board cell index, row*10 + col, range 0..199.
- `rd_data` in 3: `block_color` code. It is valid exactly 1 `Clk` after the `rd_en` cycle.
- `block_type` out 3: `block_color` of the current pixel; `EMPTY` (0) outside the play area.
- `play_area` out 1: current pixel lies inside the play area.
- `score_area` out 1: current pixel lies inside the score box.
- `DrawX_o`, `DrawY_o` out 10 each: `DrawX`/`DrawY` delayed to align with the outputs above.

## Operation
- Line buffer: 10 entries of 3 bits, indexed by column.
- Next line: `ny` = (`DrawY` == 524) ? 0 : `DrawY` + 1.
- Fetch trigger: `pix_ce` with `DrawX` == 640, FSM in IDLE, and `ny` in [`PLAY_Y0`, `PLAY_Y0`+319].
  - The trigger latches row = (`ny` − `PLAY_Y0`) >> `CELL_LOG2`, which is 0..19.
  - If `ny` is outside that range, no fetch occurs and the buffer is kept.
- FSM states:
  - IDLE: `rd_en` = 0. Moves to REQ on trigger with col counter = 0.
  - REQ: `rd_en` = 1 with `rd_addr` = row*10 + col on every cycle for col 0..9, i.e. 10 consecutive cycles. The write of `rd_data` into buffer[col−1] trails by 1 cycle. Moves to LAST after col 9 is issued.
  - LAST: captures `rd_data` into buffer[9], `rd_en` = 0, then returns to IDLE.
- A trigger that arrives while the FSM is not in IDLE is ignored. This cannot occur in normal scanning.
- Pixel path, registered on `pix_ce`:
  - `play_area` = `DrawX` in [`PLAY_X0`, `PLAY_X0`+159] and `DrawY` in [`PLAY_Y0`, `PLAY_Y0`+319].
  - Column = (`DrawX` − `PLAY_X0`) >> `CELL_LOG2`.
  - `block_type` = buffer[column] when in the play area, else `EMPTY`.
  - `score_area` = `DrawX` in [`SCORE_X0`, `SCORE_X0`+7] and `DrawY` in [`SCORE_Y0`, `SCORE_Y0`+15].
  - `DrawX_o` and `DrawY_o` register `DrawX` and `DrawY`.
- Subtractions use 11-bit arithmetic with a range check first, so no underflow aliasing occurs.

## Timing
- Reset, asynchronous: FSM = IDLE, col = 0, `rd_en` = 0, `rd_addr` = 0, buffer = all `EMPTY`. `block_type` = `EMPTY`, `play_area` = 0, `score_area` = 0, `DrawX_o` = 0, `DrawY_o` = 0.
- Reset asserted mid-fetch aborts the fetch. After release the FSM waits for the next trigger.
- Pixel-path latency is 1 `pix_ce`. All outputs, including `DrawX_o`/`DrawY_o`, change only on `Clk` edges where `pix_ce` = 1.
- A fetch takes 11 `Clk` cycles from trigger to IDLE. That is ≤ 6 pixel periods, which completes well inside the 160-pixel hblank.
- The buffer is stable for the entire active portion of every play-area line.
- Board writes during a frame become visible at the next fetch of the affected row.
- `DrawY` = 524 → `ny` = 0 wraps correctly. With `PLAY_Y0` ≥ 1 this produces no fetch.

## Test plan
- Reset release, then scan `DrawY` = 78 through `DrawX` = 640 → no `rd_en`. At `DrawY` = 79, `DrawX` = 640 → `rd_addr` = 0..9 on 10 consecutive cycles, then `rd_en` = 0.
- RAM preloaded with cell 13 = `ORANGE` (3), all others `EMPTY`. Pixel (288, 100) → one `pix_ce` later `block_type` = 3, `play_area` = 1, `DrawX_o` = 288. Pixel (287, 100) → `block_type` = 0 from col 2.
- `DrawY` = 95, `DrawX` = 640 → fetch of `rd_addr` 10..19. `DrawY` = 399 → no fetch, since `ny` = 400 is outside the play area.
- Pixels (10, 10) and (17, 25) → `score_area` = 1. Pixels (18, 25) and (10, 26) → `score_area` = 0. Pixel (399, 80) → `play_area` = 1; (400, 80) → `play_area` = 0, `block_type` = `EMPTY`.
- Assert `Reset_n` low for 2 cycles at the 5th `rd_en` cycle → `rd_en` drops asynchronously and the buffer reads `EMPTY`. The next trigger re-fetches correctly.
- Hold `pix_ce` = 0 for 20 cycles → outputs hold their values. The fetch FSM still advances on `Clk`.
